led_pattern_gen: RTL
====================

Name: led_pattern_gen

Overview:
Parametrised LED pattern engine driving an N-wide LED bank from the board 50 MHz clock. It supports four selectable patterns, four speed ranges, pause, and optional output inversion for active-low boards. It sits at top level between the board switches/keys and the LED pins, and exports a step strobe for other blocks that must track the pattern.

Parameters:
N_LEDS, 8, LED count; legal range 2..32.
DIV, 30000000, base step period in clk_50 cycles (0.6 s at 50 MHz); minimum 2.
INVERT, 0, when 1 the LED outputs are inverted (active-low LEDs).
SYNC_STAGES, 2, flip-flop stages on the mode, speed and pause inputs; minimum 2.

Ports:
clk_50  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
mode  in  2  pattern select; async switch input
speed  in  2  step period = DIV << speed; async switch input
pause  in  1  high = freeze pattern and prescaler; async key input
led_arr  out  N_LEDS  registered LED drive
step  out  1  one-cycle pulse on each pattern advance
mode_q  out  2  synchronised active mode, for status display

Behaviour:
- Reset: async assert, sync release. Clock and reset: single clock clk_50; rst_n is asynchronous, active-low.
- Reset values:
  - pattern = all ones; mode_q = FILL; dir = RIGHT.
  - Prescaler = 0; step = 0.
  - led_arr = all ones ^ {N_LEDS{INVERT}}.
  - Synchroniser flops = 0.
- Inputs: mode, speed and pause each pass through SYNC_STAGES flops. Response latency from a pin change is SYNC_STAGES+1 cycles.
- Prescaler:
  - Width = clog2(DIV<<3).
  - Period P = DIV << speed_s.
  - Each cycle, when not paused: if cnt >= P-1, then tick = 1 and cnt <= 0; else cnt++.
  - The >= comparison means lowering the speed mid-count ticks on the next cycle instead of waiting for a wrap.
  - While paused, cnt holds and no tick occurs.
- Mode change: when mode_s != mode_q:
  - mode_q <= mode_s, pattern <= init(mode_s), dir <= RIGHT, cnt <= 0.
  - No step is produced. This takes priority over a coincident tick, and it occurs even while paused.
- Patterns, advanced on each tick (step = 1 in the same cycle the pattern register updates):
  - FILL (0): init all ones. Next = (pattern == 0) ? all ones : pattern >> 1. Cycle length N_LEDS+1.
  - ROTATE (1): init MSB only. Rotate right; LSB wraps to MSB. Cycle length N_LEDS.
  - BOUNCE (2): init MSB only, dir RIGHT.
    - Shift in dir.
    - On the tick that moves the bit into LSB, dir <= LEFT; on the tick that moves it into MSB, dir <= RIGHT.
    - Each end is lit for exactly one step; cycle length 2*N_LEDS-2.
  - COUNT (3): init 0. Pattern + 1, wrapping from all ones to 0.
- Output: led_arr = pattern ^ {N_LEDS{INVERT}}, registered with no extra latency beyond the pattern register. The step output is registered.
- Reset asserted mid-step: everything returns to reset values immediately; no glitch requirements beyond the registered outputs.

Decomposition:
- Package led_pkg:
  - Mode enum: FILL = 2'd0, ROTATE = 2'd1, BOUNCE = 2'd2, COUNT = 2'd3.
  - Direction enum: RIGHT, LEFT.
  - Function init_pattern(mode, n).
- Sub-module led_tick_gen: the prescaler with speed scaling and pause, emitting tick. Synchronisers stay inline in the top.

Test Plan (DIV = 4, N_LEDS = 4, SYNC_STAGES = 2, INVERT = 0 unless stated):
1. Reset, then mode = 0, speed = 0 → led_arr 1111, 0111, 0011, 0001, 0000, 1111, one step every 4 cycles, step pulses one cycle wide.
2. Mode 2 → after 3 cycles led_arr = 1000 with no step. Then 0100, 0010, 0001, 0010, 0100, 1000, 0100 at 4-cycle spacing.
3. Mode 1, speed = 2 → step spacing is 16 cycles. Sequence 1000, 0100, 0010, 0001, 1000.
4. Speed 3 → 0 when cnt = 10 → tick on the next cycle, then spacing of 4.
5. Pause asserted mid-count for 50 cycles → led_arr and cnt frozen, no step.
   - Release → the remaining count completes with no lost or extra steps.
   - A mode change to 3 while paused → led_arr = 0000 after 3 cycles.
6. INVERT = 1 with mode 3 → led_arr 1111, 1110, 1101; rst_n pulsed low asynchronously mid-run → led_arr = 0000 (all ones inverted) immediately, and mode_q = 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern engine.
package led_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        ROTATE = 2'd1,
        BOUNCE = 2'd2,
        COUNT  = 2'd3
    } mode_e;

    typedef enum logic {
        RIGHT = 1'b0,
        LEFT  = 1'b1
    } dir_e;

    localparam int unsigned MaxLeds = 32;

    // Starting pattern for a mode; callers truncate to their own LED count.
    function automatic logic [MaxLeds-1:0] init_pattern(mode_e mode, int unsigned n);
        logic [MaxLeds-1:0] p;
        p = '0;
        case (mode)
            FILL: begin
                for (int unsigned i = 0; i < MaxLeds; i++) begin
                    if (i < n) p[i] = 1'b1;
                end
            end
            ROTATE, BOUNCE: p = MaxLeds'(1) << (n - 1);
            default:        p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: period DIV << speed, frozen while paused, cleared on mode change.
module led_tick_gen #(
    parameter int unsigned DIV = 30000000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic [1:0] speed_i,
    input  logic       pause_i,
    input  logic       clear_i,
    output logic       tick_o
);

    localparam int unsigned CntW = $clog2(DIV << 3);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     last;

    assign last = (DIV << speed_i) - 32'd1;

    // >= rather than == so a speed-up mid-count fires at once instead of wrapping.
    assign tick_o = !pause_i && (32'(cnt_q) >= last);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (!pause_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: synchronised switch inputs, four patterns, registered LED drive.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS      = 8,
    parameter int unsigned DIV         = 30000000,
    parameter bit          INVERT      = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [1:0]        speed,
    input  logic              pause,
    output logic [N_LEDS-1:0] led_arr,
    output logic              step,
    output logic [1:0]        mode_q
);

    localparam logic [N_LEDS-1:0] Ones = '1;
    localparam logic [N_LEDS-1:0] Mask = {N_LEDS{INVERT}};

    // Bundle {pause, speed, mode} through one shared synchroniser chain.
    logic [SYNC_STAGES-1:0][4:0] sync_q;
    mode_e                       mode_s;
    logic [1:0]                  speed_s;
    logic                        pause_s;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {pause, speed, mode}};
        end
    end

    assign mode_s  = mode_e'(sync_q[SYNC_STAGES-1][1:0]);
    assign speed_s = sync_q[SYNC_STAGES-1][3:2];
    assign pause_s = sync_q[SYNC_STAGES-1][4];

    mode_e             cur_mode_q, cur_mode_d;
    dir_e              dir_q, dir_d;
    logic [N_LEDS-1:0] pattern_q, pattern_d;
    logic [N_LEDS-1:0] led_q;
    logic              step_q, step_d;
    logic              mode_chg;
    logic              tick;

    assign mode_chg = (mode_s != cur_mode_q);

    led_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk_50  (clk_50),
        .rst_n   (rst_n),
        .speed_i (speed_s),
        .pause_i (pause_s),
        .clear_i (mode_chg),
        .tick_o  (tick)
    );

    always_comb begin
        cur_mode_d = cur_mode_q;
        dir_d      = dir_q;
        pattern_d  = pattern_q;
        step_d     = 1'b0;
        // A mode change wins over a coincident tick and applies even while paused.
        if (mode_chg) begin
            cur_mode_d = mode_s;
            pattern_d  = N_LEDS'(init_pattern(mode_s, N_LEDS));
            dir_d      = RIGHT;
        end else if (tick) begin
            step_d = 1'b1;
            case (cur_mode_q)
                FILL:   pattern_d = (pattern_q == '0) ? Ones : (pattern_q >> 1);
                ROTATE: pattern_d = {pattern_q[0], pattern_q[N_LEDS-1:1]};
                BOUNCE: begin
                    if (dir_q == RIGHT) begin
                        pattern_d = pattern_q >> 1;
                        if (pattern_d[0]) dir_d = LEFT;
                    end else begin
                        pattern_d = pattern_q << 1;
                        if (pattern_d[N_LEDS-1]) dir_d = RIGHT;
                    end
                end
                default: pattern_d = pattern_q + N_LEDS'(1);
            endcase
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cur_mode_q <= FILL;
            dir_q      <= RIGHT;
            pattern_q  <= Ones;
            led_q      <= Ones ^ Mask;
            step_q     <= 1'b0;
        end else begin
            cur_mode_q <= cur_mode_d;
            dir_q      <= dir_d;
            pattern_q  <= pattern_d;
            led_q      <= pattern_d ^ Mask;
            step_q     <= step_d;
        end
    end

    assign led_arr = led_q;
    assign step    = step_q;
    assign mode_q  = cur_mode_q;

endmodule
